// File: rtl/noc_xbar_rr.sv
// noc_xbar_rr: registered N-port NoC crossbar with per-output round-robin
// arbitration, wormhole packet locking and a valid/ready output stage.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_n_i      asynchronous active-low reset
//   in_data_i    head flit of each input queue, slice i = [i*DW +: DW]
//   in_valid_i   input queue i non-empty
//   in_dest_i    requested output port per input, slice i = [i*PW +: PW]
//   in_tail_i    flit is the last of its packet
//   in_pop_o     combinational pop strobe back to each input queue
//   out_data_o   registered output flit per port
//   out_valid_o  output register holds a flit
//   out_ready_i  downstream accepts the output flit this cycle
module noc_xbar_rr #(
    parameter  int unsigned NPORTS = 5,
    parameter  int unsigned DW     = 16,
    localparam int unsigned PW     = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [NPORTS*DW-1:0] in_data_i,
    input  logic [NPORTS-1:0]    in_valid_i,
    input  logic [NPORTS*PW-1:0] in_dest_i,
    input  logic [NPORTS-1:0]    in_tail_i,
    output logic [NPORTS-1:0]    in_pop_o,
    output logic [NPORTS*DW-1:0] out_data_o,
    output logic [NPORTS-1:0]    out_valid_o,
    input  logic [NPORTS-1:0]    out_ready_i
);

    logic [NPORTS-1:0]             out_valid_q, out_valid_d;
    logic [NPORTS-1:0][DW-1:0]     out_data_q,  out_data_d;
    logic [NPORTS-1:0]             lock_q,      lock_d;
    logic [NPORTS-1:0][PW-1:0]     owner_q,     owner_d;
    logic [NPORTS-1:0][PW-1:0]     rr_q,        rr_d;

    logic [NPORTS-1:0][NPORTS-1:0] req_c;      // [output][input]
    logic [NPORTS-1:0]             gnt_vld_c;
    logic [NPORTS-1:0][PW-1:0]     gnt_idx_c;
    logic [NPORTS-1:0]             pop_c;

    // Request matrix; a dest outside 0..NPORTS-1 matches no output and is never served.
    always_comb begin
        req_c = '0;
        for (int unsigned o = 0; o < NPORTS; o++) begin
            for (int unsigned i = 0; i < NPORTS; i++) begin
                req_c[o][i] = in_valid_i[i] && (in_dest_i[i*PW +: PW] == PW'(o));
            end
        end
    end

    // Per-output arbiter: lock owner only when locked, else round-robin from rr pointer.
    always_comb begin
        int unsigned cand;
        cand      = 0;
        gnt_vld_c = '0;
        gnt_idx_c = '0;
        for (int unsigned o = 0; o < NPORTS; o++) begin
            if (lock_q[o]) begin
                for (int unsigned i = 0; i < NPORTS; i++) begin
                    if (req_c[o][i] && (owner_q[o] == PW'(i))) begin
                        gnt_vld_c[o] = 1'b1;
                        gnt_idx_c[o] = PW'(i);
                    end
                end
            end else begin
                for (int unsigned k = 0; k < NPORTS; k++) begin
                    cand = 32'(rr_q[o]) + k;
                    if (cand >= NPORTS) begin
                        cand = cand - NPORTS;
                    end
                    if (!gnt_vld_c[o] && req_c[o][PW'(cand)]) begin
                        gnt_vld_c[o] = 1'b1;
                        gnt_idx_c[o] = PW'(cand);
                    end
                end
            end
        end
    end

    // Transfer, pop generation and per-output state update.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        lock_d      = lock_q;
        owner_d     = owner_q;
        rr_d        = rr_q;
        pop_c       = '0;
        for (int unsigned o = 0; o < NPORTS; o++) begin
            // Loading while the current flit drains gives back-to-back flits.
            if (gnt_vld_c[o] && (!out_valid_q[o] || out_ready_i[o])) begin
                out_valid_d[o] = 1'b1;
                for (int unsigned i = 0; i < NPORTS; i++) begin
                    if (gnt_idx_c[o] == PW'(i)) begin
                        out_data_d[o] = in_data_i[i*DW +: DW];
                        pop_c[i]      = 1'b1;
                        if (in_tail_i[i]) begin
                            lock_d[o] = 1'b0;
                            rr_d[o]   = (i == NPORTS - 1) ? '0 : PW'(i + 1);
                        end else begin
                            lock_d[o]  = 1'b1;
                            owner_d[o] = PW'(i);
                        end
                    end
                end
            end else if (out_ready_i[o]) begin
                out_valid_d[o] = 1'b0;
            end
        end
    end

    // No pops may leak to the queues while the switch is held in reset.
    assign in_pop_o = rst_n_i ? pop_c : '0;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_valid_q <= '0;
            out_data_q  <= '0;
            lock_q      <= '0;
            owner_q     <= '0;
            rr_q        <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            lock_q      <= lock_d;
            owner_q     <= owner_d;
            rr_q        <= rr_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;

endmodule

// File: tb/tb_noc_xbar_rr.sv
// tb_noc_xbar_rr: directed self-checking bench for noc_xbar_rr (5 ports, 16-bit flits).
module tb_noc_xbar_rr;

    localparam int unsigned N  = 5;
    localparam int unsigned DW = 16;
    localparam int unsigned PW = 3;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N-1:0][DW-1:0] in_data;
    logic [N-1:0]         in_valid;
    logic [N-1:0][PW-1:0] in_dest;
    logic [N-1:0]         in_tail;
    logic [N-1:0]         in_pop;
    logic [N-1:0][DW-1:0] out_data;
    logic [N-1:0]         out_valid;
    logic [N-1:0]         out_ready;

    int checks = 0;
    int errors = 0;

    noc_xbar_rr #(.NPORTS(N), .DW(DW)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .in_dest_i   (in_dest),
        .in_tail_i   (in_tail),
        .in_pop_o    (in_pop),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        in_valid = '0;
        in_tail  = '0;
        in_dest  = '0;
        in_data  = '0;
    endtask

    task automatic send(input logic [2:0] i, input logic [15:0] d, input logic [2:0] dst,
                        input logic t);
        in_valid[i] = 1'b1;
        in_data[i]  = d;
        in_dest[i]  = dst;
        in_tail[i]  = t;
    endtask

    task automatic drain();
        clear_in();
        out_ready = '1;
        tick();
        tick();
    endtask

    logic [2:0] ord [6];

    initial begin
        // Reset: registers clear, pops suppressed even with live requests.
        rst_n     = 1'b0;
        out_ready = '1;
        in_valid  = '1;
        in_tail   = '1;
        in_dest   = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        in_data   = {5{16'h1234}};
        #2;
        chk("rst_valid", 128'(out_valid), 128'(0));
        chk("rst_data", 128'(out_data), 128'(0));
        chk("rst_pop", 128'(in_pop), 128'(0));
        tick();
        chk("rst_valid_edge", 128'(out_valid), 128'(0));
        chk("rst_pop_edge", 128'(in_pop), 128'(0));
        clear_in();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single flit local -> north.
        send(3'd4, 16'hA5A5, 3'd0, 1'b1);
        #1;
        chk("single_pop", 128'(in_pop), 128'(5'b10000));
        tick();
        clear_in();
        #1;
        chk("single_valid", 128'(out_valid), 128'(5'b00001));
        chk("single_data", 128'(out_data[0]), 128'(16'hA5A5));
        chk("single_pop_idle", 128'(in_pop), 128'(0));
        tick();
        chk("single_fall", 128'(out_valid), 128'(0));
        drain();

        // Round-robin on output 0 (pointer wrapped to 0 after input 4's tail).
        ord = '{3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3};
        send(3'd1, 16'h0101, 3'd0, 1'b1);
        send(3'd2, 16'h0102, 3'd0, 1'b1);
        send(3'd3, 16'h0103, 3'd0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("rr_pop%0d", k), 128'(in_pop), 128'(5'(1) << ord[k]));
            tick();
            chk($sformatf("rr_data%0d", k), 128'(out_data[0]), 128'(16'h0100 + 16'(ord[k])));
            chk($sformatf("rr_valid%0d", k), 128'(out_valid[0]), 128'(1'b1));
        end
        drain();

        // Wormhole lock on output 1: owner 2 holds it even while idle.
        send(3'd2, 16'd11, 3'd1, 1'b0);
        #1;
        chk("wh_pop1", 128'(in_pop), 128'(5'b00100));
        tick();
        chk("wh_data1", 128'(out_data[1]), 128'(16'd11));
        send(3'd2, 16'd22, 3'd1, 1'b0);
        send(3'd0, 16'h00AA, 3'd1, 1'b1);
        #1;
        chk("wh_pop2", 128'(in_pop), 128'(5'b00100));
        tick();
        chk("wh_data2", 128'(out_data[1]), 128'(16'd22));
        in_valid[2] = 1'b0;
        #1;
        chk("wh_pop_idle_owner", 128'(in_pop), 128'(0));
        tick();
        chk("wh_bubble", 128'(out_valid[1]), 128'(1'b0));
        send(3'd2, 16'd33, 3'd1, 1'b1);
        #1;
        chk("wh_pop3", 128'(in_pop), 128'(5'b00100));
        tick();
        chk("wh_data3", 128'(out_data[1]), 128'(16'd33));
        in_valid[2] = 1'b0;
        #1;
        chk("wh_pop_other", 128'(in_pop), 128'(5'b00001));
        tick();
        chk("wh_data_other", 128'(out_data[1]), 128'(16'h00AA));
        chk("wh_valid_other", 128'(out_valid[1]), 128'(1'b1));
        drain();

        // Backpressure on output 3 must not stall output 2.
        send(3'd0, 16'hB000, 3'd3, 1'b1);
        send(3'd1, 16'hC000, 3'd2, 1'b1);
        #1;
        chk("bp_pop_load", 128'(in_pop), 128'(5'b00011));
        tick();
        chk("bp_hold_data0", 128'(out_data[3]), 128'(16'hB000));
        in_data[0] = 16'hB001;
        for (int k = 0; k < 4; k++) begin
            out_ready[3] = 1'b0;
            in_data[1]   = 16'hC001 + 16'(k);
            #1;
            chk($sformatf("bp_pop%0d", k), 128'(in_pop), 128'(5'b00010));
            tick();
            chk($sformatf("bp_hold%0d", k), 128'(out_data[3]), 128'(16'hB000));
            chk($sformatf("bp_v3_%0d", k), 128'(out_valid[3]), 128'(1'b1));
            chk($sformatf("bp_stream%0d", k), 128'(out_data[2]), 128'(16'hC001 + 16'(k)));
        end
        out_ready[3] = 1'b1;
        in_data[1]   = 16'hC005;
        #1;
        chk("bp_pop_release", 128'(in_pop), 128'(5'b00011));
        tick();
        chk("bp_release_data", 128'(out_data[3]), 128'(16'hB001));
        chk("bp_release_data2", 128'(out_data[2]), 128'(16'hC005));
        drain();

        // All five ports in parallel, each to the next port.
        send(3'd0, 16'h00D0, 3'd1, 1'b1);
        send(3'd1, 16'h00D1, 3'd2, 1'b1);
        send(3'd2, 16'h00D2, 3'd3, 1'b1);
        send(3'd3, 16'h00D3, 3'd4, 1'b1);
        send(3'd4, 16'h00D4, 3'd0, 1'b1);
        #1;
        chk("par_pop", 128'(in_pop), 128'(5'b11111));
        tick();
        clear_in();
        chk("par_valid", 128'(out_valid), 128'(5'b11111));
        chk("par_d0", 128'(out_data[0]), 128'(16'h00D4));
        chk("par_d1", 128'(out_data[1]), 128'(16'h00D0));
        chk("par_d2", 128'(out_data[2]), 128'(16'h00D1));
        chk("par_d3", 128'(out_data[3]), 128'(16'h00D2));
        chk("par_d4", 128'(out_data[4]), 128'(16'h00D3));
        drain();

        // Illegal destinations are never granted nor popped.
        send(3'd0, 16'hDEAD, 3'd5, 1'b1);
        send(3'd3, 16'hBEEF, 3'd7, 1'b1);
        #1;
        chk("illegal_pop", 128'(in_pop), 128'(0));
        tick();
        chk("illegal_valid", 128'(out_valid), 128'(0));
        drain();

        // Reset in the middle of a 4-flit packet to output 3.
        send(3'd1, 16'h00E1, 3'd3, 1'b0);
        #1;
        chk("rstm_pop1", 128'(in_pop), 128'(5'b00010));
        tick();
        send(3'd1, 16'h00E2, 3'd3, 1'b0);
        #1;
        chk("rstm_pop2", 128'(in_pop), 128'(5'b00010));
        tick();
        chk("rstm_data2", 128'(out_data[3]), 128'(16'h00E2));
        rst_n = 1'b0;
        #1;
        chk("rstm_async_valid", 128'(out_valid), 128'(0));
        chk("rstm_async_pop", 128'(in_pop), 128'(0));
        #2;
        rst_n = 1'b1;
        clear_in();
        send(3'd2, 16'h00F2, 3'd3, 1'b1);
        #1;
        chk("rstm_newgrant_pop", 128'(in_pop), 128'(5'b00100));
        tick();
        chk("rstm_new_data", 128'(out_data[3]), 128'(16'h00F2));
        chk("rstm_new_valid", 128'(out_valid), 128'(5'b01000));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
